lcd_gdram_sink: RTL and testbench
=================================

LCD_GDRAM_SINK -- requirements
Module: lcd_gdram_sink

Interface
REQ-001 SHALL have port clk  in  1  system clock, 50 MHz.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port rs  in  1  LCD register select; 0 = command, 1 = data.
REQ-004 SHALL have port rw  in  1  LCD read/write; 1 = read (unsupported), 0 = write.
REQ-005 SHALL have port en  in  1  LCD enable, asynchronous to clk; a transfer completes on its falling edge.
REQ-006 SHALL have port data  in  8  LCD bus byte.
REQ-007 SHALL have port gd_we  out  1  one-cycle GDRAM word write strobe.
REQ-008 SHALL have port gd_addr  out  9  word address {y[4:0], x[3:0]}.
REQ-009 SHALL have port gd_wdata  out  16  GDRAM word, high byte first on the bus.
REQ-010 SHALL have port clr_pulse  out  1  one-cycle pulse on display clear (0x01, basic mode).
REQ-011 SHALL have ports ext_mode, graphic_on, display_on, entry_inc  out  1 each  decoded mode flags.
REQ-012 SHALL have port err_cnt  out  8  saturating count of ignored transfers.

Function
REQ-013 SHALL synchronise en through two flops and detect a falling edge (synced 1 -> 0) as one transfer event.
REQ-014 SHALL capture rs, rw and data every cycle while synced en is 1 and use the last captured values at the event; en high SHALL last at least 3 clk cycles.
REQ-015 SHALL ignore a transfer with rw=1, except to increment err_cnt, which saturates at 255.
REQ-016 SHALL decode the function set (data[7:5]=001) in either mode: ext_mode <= data[2]; graphic_on <= data[1] only when data[2]=1.
REQ-017 SHALL decode in basic mode: 0x01 -> clr_pulse, address reset to 0, byte phase reset; 0000_01xx -> entry_inc <= data[1]; 0000_1xxx -> display_on <= data[2].
REQ-018 SHALL decode in extended mode: the first 1xxx_xxxx command loads y <= data[4:0]; the next 1xxx_xxxx command loads x <= data[3:0]. Address SM states: ADDR_Y (awaiting y), ADDR_X (awaiting x).
REQ-019 SHALL return the address SM to ADDR_Y on any non-address command, or on a data write, received while in ADDR_X, without changing x.
REQ-020 SHALL ignore, and count in err_cnt, any other command code in either mode.
REQ-021 SHALL treat a data write (rs=1) as follows: byte phase HI latches the high byte and moves to LO; phase LO asserts gd_we for exactly one cycle with gd_addr={y,x} and gd_wdata={hi,data}, then returns to HI.
REQ-022 SHALL, after each word write, advance x by +1 when entry_inc=1 and -1 when entry_inc=0, wrapping modulo 16; y SHALL remain unchanged.
REQ-023 SHALL discard a pending high byte (phase back to HI) on any command transfer.
REQ-024 SHALL accept data written before any address command at the current address (0 after reset).
REQ-025 SHALL assert gd_we in the cycle after the event cycle, giving latency from the synced falling edge to gd_we of 1 clk.
REQ-026 SHALL hold gd_addr and gd_wdata stable until the next gd_we.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, clear gd_we, clr_pulse, gd_addr, gd_wdata, err_cnt, ext_mode, graphic_on and display_on to 0, set entry_inc to 1, set the address SM to ADDR_Y and the byte phase to HI, and clear the en synchroniser to 0.
REQ-028 SHALL abort any transfer in progress during reset; a falling en edge that spans the deassertion of reset SHALL NOT produce an event.

Structure
REQ-029 SHALL place command opcodes (0x30, 0x36, 0x06, 0x0C, 0x01, 0x80 mask) and state encodings in the shared package lcd_pkg.
REQ-030 SHALL implement the synchroniser and edge detector as sub-module lcd_en_sync.

Verification
REQ-031 Reset, then send 0x30, 0x06, 0x0C -> display_on=1, entry_inc=1, ext_mode=0, err_cnt=0.
REQ-032 Send 0x36, 0x85, 0x83, then data 0xAA, 0x55 -> one gd_we with gd_addr=0x053 and gd_wdata=0xAA55; x is then 4.
REQ-033 From x=15, y=2, write 2 words -> gd_addr 0x02F, then 0x020.
REQ-034 Send 0x36, 0x84, 0x0C, 0x81, 0x82 -> y=1, x=2, and err_cnt increments by 1 for the 0x0C.
REQ-035 Write data 0x12, then command 0x80, 0x80, then data 0x34, 0x56 -> exactly one gd_we, with gd_wdata=0x3456 at gd_addr=0x000.
REQ-036 Issue 300 transfers with rw=1 -> no gd_we, err_cnt=255; then assert rst in the middle of a transfer -> all outputs at reset values and no spurious gd_we.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared opcodes, state encodings and mode-flag record for the LCD GDRAM sink.
package lcd_pkg;

    localparam logic [7:0] CMD_BASIC     = 8'h30;
    localparam logic [7:0] CMD_EXT_GFX   = 8'h36;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ADDR_MASK = 8'h80;

    localparam logic [0:0] ADDR_Y   = 1'b0;
    localparam logic [0:0] ADDR_X   = 1'b1;
    localparam logic [0:0] PHASE_HI = 1'b0;
    localparam logic [0:0] PHASE_LO = 1'b1;

    typedef struct packed {
        logic ext_mode;
        logic graphic_on;
        logic display_on;
        logic entry_inc;
    } mode_t;

endpackage

// File: rtl/lcd_gdram_sink_if.sv
// Parallel LCD bus as seen by the sink. en is asynchronous to the sink clock;
// rs/rw/data must stay valid while en is high and a few clocks after it falls.
interface lcd_gdram_sink_if;
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] data;

    modport master (output rs, rw, en, data);
    modport slave  (input  rs, rw, en, data);
endinterface

// File: rtl/lcd_en_sync.sv
// Two-flop synchroniser for the LCD enable plus a falling-edge detector.
module lcd_en_sync (
    input  logic clk,
    input  logic rst,
    input  logic en_async,
    output logic en_sync,
    output logic en_fall
);
    logic s1, s2, prev, settled, armed;

    // Only qualify the enable after a genuine low has been sampled post-reset,
    // so a strobe that straddles reset release never yields an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            prev    <= 1'b0;
            settled <= 1'b0;
            armed   <= 1'b0;
        end else begin
            s1      <= en_async;
            s2      <= s1;
            settled <= 1'b1;
            if (settled && !s1)
                armed <= 1'b1;
            prev    <= en_sync;
        end
    end

    assign en_sync = s2 & armed;
    assign en_fall = prev & ~en_sync;
endmodule

// File: rtl/lcd_gdram_sink.sv
// Write-only LCD controller front end: decodes basic/extended commands and
// assembles high/low data bytes into GDRAM word writes.
module lcd_gdram_sink
    import lcd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    lcd_gdram_sink_if.slave        bus,
    output logic                   gd_we,
    output logic [8:0]             gd_addr,
    output logic [15:0]            gd_wdata,
    output logic                   clr_pulse,
    output logic                   ext_mode,
    output logic                   graphic_on,
    output logic                   display_on,
    output logic                   entry_inc,
    output logic [7:0]             err_cnt,
    output logic [1:0]             dbg_state
);
    logic       en_sync, ev;
    logic       cap_rs, cap_rw;
    logic [7:0] cap_data;
    logic [0:0] addr_st, phase;
    logic [4:0] y;
    logic [3:0] x;
    logic [7:0] hi_byte;
    logic       cmd_fset, cmd_addr, cmd_clear, cmd_entry, cmd_disp, bump_err;

    lcd_en_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .en_async (bus.en),
        .en_sync  (en_sync),
        .en_fall  (ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else if (en_sync) begin
            cap_rs   <= bus.rs;
            cap_rw   <= bus.rw;
            cap_data <= bus.data;
        end
    end

    always_comb begin
        cmd_fset  = (cap_data[7:5] == 3'b001);
        cmd_addr  = ext_mode && ((cap_data & CMD_ADDR_MASK) != 8'h00);
        cmd_clear = !ext_mode && (cap_data == CMD_CLEAR);
        cmd_entry = !ext_mode && (cap_data[7:2] == 6'b000001);
        cmd_disp  = !ext_mode && (cap_data[7:3] == 5'b00001);
        bump_err  = ev && (cap_rw ||
                    (!cap_rs && !(cmd_fset || cmd_addr || cmd_clear || cmd_entry || cmd_disp)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gd_we      <= 1'b0;
            clr_pulse  <= 1'b0;
            gd_addr    <= 9'd0;
            gd_wdata   <= 16'd0;
            err_cnt    <= 8'd0;
            ext_mode   <= 1'b0;
            graphic_on <= 1'b0;
            display_on <= 1'b0;
            entry_inc  <= 1'b1;
            addr_st    <= ADDR_Y;
            phase      <= PHASE_HI;
            x          <= 4'd0;
            y          <= 5'd0;
            hi_byte    <= 8'h00;
        end else begin
            gd_we     <= 1'b0;
            clr_pulse <= 1'b0;
            if (bump_err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (ev && !cap_rw) begin
                if (cap_rs) begin
                    addr_st <= ADDR_Y;
                    if (phase == PHASE_HI) begin
                        hi_byte <= cap_data;
                        phase   <= PHASE_LO;
                    end else begin
                        gd_we    <= 1'b1;
                        gd_addr  <= {y, x};
                        gd_wdata <= {hi_byte, cap_data};
                        phase    <= PHASE_HI;
                        x        <= entry_inc ? x + 4'd1 : x - 4'd1;
                    end
                end else begin
                    phase   <= PHASE_HI;
                    addr_st <= ADDR_Y;
                    if (cmd_fset) begin
                        ext_mode <= cap_data[2];
                        if (cap_data[2])
                            graphic_on <= cap_data[1];
                    end else if (cmd_addr) begin
                        // y first, then x; a stray command in between restarts at y.
                        if (addr_st == ADDR_Y) begin
                            y       <= cap_data[4:0];
                            addr_st <= ADDR_X;
                        end else begin
                            x <= cap_data[3:0];
                        end
                    end else if (cmd_clear) begin
                        clr_pulse <= 1'b1;
                        x         <= 4'd0;
                        y         <= 5'd0;
                    end else if (cmd_entry) begin
                        entry_inc <= cap_data[1];
                    end else if (cmd_disp) begin
                        display_on <= cap_data[2];
                    end
                end
            end
        end
    end

    assign dbg_state = {addr_st, phase};
endmodule

// File: tb/tb_lcd_gdram_sink.sv
// Bench for lcd_gdram_sink: table of command vectors checking mode flags, then
// hand sequences whose GDRAM writes are scored against an expected queue.
module tb_lcd_gdram_sink;
    import lcd_pkg::*;

    logic        clk, rst;
    logic        gd_we, clr_pulse, ext_mode, graphic_on, display_on, entry_inc;
    logic [8:0]  gd_addr;
    logic [15:0] gd_wdata;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int we_seen = 0;
    int clr_seen = 0;
    logic [24:0] exp_q[$];

    lcd_gdram_sink_if bus ();

    lcd_gdram_sink dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .gd_we      (gd_we),
        .gd_addr    (gd_addr),
        .gd_wdata   (gd_wdata),
        .clr_pulse  (clr_pulse),
        .ext_mode   (ext_mode),
        .graphic_on (graphic_on),
        .display_on (display_on),
        .entry_inc  (entry_inc),
        .err_cnt    (err_cnt),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Scoreboard: every gd_we must match the oldest expected {addr, wdata}.
    always @(negedge clk) begin
        if (clr_pulse) clr_seen++;
        if (gd_we) begin
            we_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gd_we: got addr=%03h wdata=%04h, required no write", gd_addr, gd_wdata);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                if ({gd_addr, gd_wdata} !== e) begin
                    errors++;
                    $display("FAIL gd_word: got addr=%03h wdata=%04h, required addr=%03h wdata=%04h",
                             gd_addr, gd_wdata, e[24:16], e[15:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic check_flags(input string name, input logic [3:0] req_f, input logic [7:0] req_e);
        check({name, "_flags"}, {28'd0, ext_mode, graphic_on, display_on, entry_inc}, {28'd0, req_f});
        check({name, "_err"}, {24'd0, err_cnt}, {24'd0, req_e});
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input logic rs_v, input logic rw_v, input logic [7:0] d);
        @(negedge clk);
        bus.rs = rs_v; bus.rw = rw_v; bus.data = d;
        bus.en = 1'b1;
        repeat (4) @(negedge clk);
        bus.en = 1'b0;
        repeat (4) @(negedge clk);
        bus.data = 8'($urandom_range(0, 255));
        bus.rs = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] d);
        xfer(1'b0, 1'b0, d);
    endtask

    task automatic word(input logic [8:0] a, input logic [15:0] w);
        exp_q.push_back({a, w});
        xfer(1'b1, 1'b0, w[15:8]);
        xfer(1'b1, 1'b0, w[7:0]);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        logic [3:0] exp_f;  // {ext_mode, graphic_on, display_on, entry_inc}
        logic [7:0] exp_e;
    } vec_t;

    vec_t vecs[17];
    int   we_before;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, CMD_BASIC,     4'b0001, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, CMD_ENTRY_INC, 4'b0001, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, CMD_DISP_ON,   4'b0011, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'h04,         4'b0010, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h08,         4'b0000, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h0E,         4'b0010, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 8'h07,         4'b0011, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 8'h40,         4'b0011, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 8'h34,         4'b1011, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, CMD_EXT_GFX,   4'b1111, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 8'h0C,         4'b1111, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 8'h32,         4'b0111, 8'd2};
        vecs[12] = '{1'b0, 1'b0, CMD_BASIC,     4'b0111, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 8'h05,         4'b0110, 8'd2};
        vecs[14] = '{1'b0, 1'b1, 8'h06,         4'b0110, 8'd3};
        vecs[15] = '{1'b1, 1'b1, 8'hFF,         4'b0110, 8'd4};
        vecs[16] = '{1'b0, 1'b0, 8'h02,         4'b0110, 8'd5};

        do_reset();
        check("reset_we",    {31'd0, gd_we}, 32'd0);
        check("reset_clr",   {31'd0, clr_pulse}, 32'd0);
        check("reset_addr",  {23'd0, gd_addr}, 32'd0);
        check("reset_wdata", {16'd0, gd_wdata}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        check_flags("reset", 4'b0001, 8'd0);

        for (int i = 0; i < 17; i++) begin
            xfer(vecs[i].rs, vecs[i].rw, vecs[i].d);
            check_flags($sformatf("vec%0d", i), vecs[i].exp_f, vecs[i].exp_e);
        end
        drain("table");

        // First word goes to address 0, then y=5 x=3, then auto-increment to x=4.
        do_reset();
        word(9'h000, 16'hBEEF);
        cmd(CMD_EXT_GFX); cmd(8'h85); cmd(8'h83);
        word(9'h053, 16'hAA55);
        word(9'h054, 16'h0102);
        drain("addr_53");

        // Increment wraps 15 -> 0 without touching y.
        cmd(8'h82); cmd(8'h8F);
        word(9'h02F, 16'h1111);
        word(9'h020, 16'h2222);
        drain("wrap_up");

        // Stray command between y and x restarts address entry and is counted.
        do_reset();
        cmd(CMD_EXT_GFX); cmd(8'h84); cmd(8'h0C); cmd(8'h81); cmd(8'h82);
        check("stray_err", {24'd0, err_cnt}, 32'd1);
        word(9'h012, 16'h5A5A);
        drain("stray");

        // Pending high byte is dropped by a command.
        do_reset();
        cmd(CMD_EXT_GFX);
        xfer(1'b1, 1'b0, 8'h12);
        cmd(8'h80); cmd(8'h80);
        word(9'h000, 16'h3456);
        drain("discard_hi");

        // Decrementing entry wraps 0 -> 15.
        do_reset();
        cmd(8'h04); cmd(CMD_EXT_GFX); cmd(8'h80); cmd(8'h80);
        word(9'h000, 16'hC0DE);
        word(9'h00F, 16'hF00D);
        drain("wrap_down");

        // Clear: exactly one pulse and the address returns to 0.
        do_reset();
        word(9'h000, 16'h0A0B);
        clr_seen = 0;
        cmd(CMD_CLEAR);
        check("clr_count", clr_seen, 1);
        word(9'h000, 16'h0C0D);
        drain("clear");

        // Reads are ignored and counted, saturating at 255.
        do_reset();
        we_before = we_seen;
        for (int i = 0; i < 300; i++)
            xfer(1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 255)));
        check("read_err_sat", {24'd0, err_cnt}, 32'd255);
        check("read_no_we", we_seen - we_before, 0);

        // Reset lands mid-transfer; en falls just after reset release.
        xfer(1'b1, 1'b0, 8'h77);
        @(negedge clk);
        bus.rs = 1'b1; bus.rw = 1'b0; bus.data = 8'h99; bus.en = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_no_we", we_seen - we_before, 0);
        check_flags("rst_mid", 4'b0001, 8'd0);
        check("rst_mid_addr",  {23'd0, gd_addr}, 32'd0);
        check("rst_mid_wdata", {16'd0, gd_wdata}, 32'd0);
        check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
        word(9'h000, 16'hABCD);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end
endmodule
